dram_piso: RTL and testbench
============================

# dram_piso

Parallel-in, serial-out shifter for the controller's single-bit serial data path. It accepts a WIDTH-bit word through a valid/ready handshake and emits it MSB first, one bit per clock. Each bit is qualified by a valid strobe, and a marker flags the first bit of each word. A receiving dram_sipo that samples whenever out_valid is high holds the complete word after WIDTH valid bits. Back-to-back loads produce a gapless stream.

## Interface
- WIDTH, 8, word width in bits; legal range ≥ 2.
- clk  input  1  clock; all state changes on the rising edge.
- rst_b  input  1  reset; asynchronous assert, active-low.
- load_valid  input  1  data_in holds a word to send.
- data_in  input  WIDTH  parallel word; sampled only on an accepted load.
- load_ready  output  1  a load is accepted this cycle if load_valid is also high.
- data_out  output  1  serial bit, MSB first.
- out_valid  output  1  data_out holds a valid bit.
- frame_start  output  1  high during bit 0 (the MSB) of each word.
- busy  output  1  a word is being shifted (state SHIFT).

## Operation
- Registers:
  - shift_reg[WIDTH-1:0].
  - bit_cnt, width $clog2(WIDTH); counts 0..WIDTH-1 and never wraps past WIDTH-1.
  - state, one of IDLE or SHIFT.
- Outputs are driven from registers:
  - data_out = shift_reg[WIDTH-1] in SHIFT, 0 in IDLE.
  - out_valid = busy = (state==SHIFT).
  - frame_start = (state==SHIFT && bit_cnt==0).
- load_ready is combinational: (state==IDLE) || (state==SHIFT && bit_cnt==WIDTH-1).
- accept = load_valid && load_ready.
- IDLE:
  - On accept: shift_reg<=data_in, bit_cnt<=0, go to SHIFT.
  - Otherwise hold; shift_reg keeps its value.
- SHIFT, bit_cnt<WIDTH-1: shift_reg<={shift_reg[WIDTH-2:0],1'b0}, bit_cnt<=bit_cnt+1. load_valid is ignored and data_in changes have no effect.
- SHIFT, bit_cnt==WIDTH-1 (last bit):
  - On accept: shift_reg<=data_in, bit_cnt<=0, stay in SHIFT. This is the gapless back-to-back case.
  - Otherwise go to IDLE, bit_cnt<=0.
- Reset (rst_b low, at any time, including mid-word):
  - state=IDLE, shift_reg=0, bit_cnt=0.
  - Hence data_out=0, out_valid=0, frame_start=0, busy=0, load_ready=1.
  - A partially sent word is discarded and is not resumed after reset.
- There is no abort other than reset.

## Timing
- A load accepted at edge E puts the MSB on data_out in the cycle after E, with frame_start=1.
- Bit k appears in cycle E+1+k, for k=0..WIDTH-1.
- Word occupancy is exactly WIDTH cycles of out_valid.
- Throughput is one word per WIDTH cycles when load_valid is held high, with no idle cycle between words.
- load_ready is high for one cycle per word while shifting (the last-bit cycle) and continuously while IDLE.
- Release of rst_b is synchronised externally. The first accept can occur at the first clock edge after release.
- Throughout, dram_sipo (same WIDTH) fed from data_out and clocked only on out_valid cycles holds data_in of the word one edge after that word's last bit.

## Test plan
- Reset: assert rst_b low with clk running and load_valid=1 → data_out=0, out_valid=0, frame_start=0, busy=0, load_ready=1. Release reset → first accept occurs on the next edge.
- Single word, WIDTH=8, data_in=8'hA5 for one accepted cycle:
  - data_out reads 1,0,1,0,0,1,0,1 over 8 consecutive cycles starting at E+1.
  - out_valid is high for exactly 8 cycles.
  - frame_start is high only in the first of those cycles.
  - load_ready is low for the first 7 bits and high on the 8th, then returns to IDLE.
- Back-to-back: hold load_valid=1 with 8'hA5, then 8'h3C at its acceptance point → 16 contiguous valid bits A5 then 3C, frame_start at bits 0 and 8, no gap.
- Busy-time ignore: while shifting 8'hFF, toggle data_in and pulse load_valid in mid-word cycles → output stays eight 1s and no extra word is sent.
- Reset mid-word: assert rst_b after the 3rd bit of 8'hC3 → outputs are immediately 0 and load_ready=1. A new load of 8'h81 afterwards sends a clean 1,0,0,0,0,0,0,1.
- Loopback: drive 100 random words through dram_piso into a dram_sipo enabled on out_valid, with random load_valid gaps → every received word equals its sent word and the order is preserved.

Source files
------------

// File: rtl/dram_piso.sv
// Parallel-in, serial-out shifter for the single-bit serial data path.
// Takes a WIDTH-bit word on a valid/ready handshake and sends it MSB first, one bit per clock.
module dram_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             load_ready,
    output logic             data_out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt_reg;
    logic             last_bit;

    assign last_bit    = (state_reg == SHIFT) && (bit_cnt_reg == LAST_BIT);
    // The last-bit cycle doubles as the load slot so consecutive words run gapless.
    assign load_ready  = (state_reg == IDLE) || last_bit;

    assign busy        = (state_reg == SHIFT);
    assign out_valid   = (state_reg == SHIFT);
    assign data_out    = (state_reg == SHIFT) && shift_reg[WIDTH-1];
    assign frame_start = (state_reg == SHIFT) && (bit_cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_valid) begin
                        shift_reg   <= data_in;
                        bit_cnt_reg <= '0;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt_reg != LAST_BIT) begin
                        shift_reg   <= {shift_reg[WIDTH-2:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    end else if (load_valid) begin
                        shift_reg   <= data_in;
                        bit_cnt_reg <= '0;
                    end else begin
                        bit_cnt_reg <= '0;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    bit_cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_piso.sv
// Bench for dram_piso: a queue of expected serial bits models the output stream,
// and a behavioural deserialiser checks each received word against the words sent.
module tb_dram_piso;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic b;
        logic first;
    } exp_bit_t;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             load_ready;
    logic             data_out;
    logic             out_valid;
    logic             frame_start;
    logic             busy;

    dram_piso #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .load_valid  (load_valid),
        .data_in     (data_in),
        .load_ready  (load_ready),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int               n_vec = 0;
    int               n_err = 0;
    exp_bit_t         exp_q[$];
    logic [WIDTH-1:0] sent_q[$];
    logic [WIDTH-1:0] rx_word = '0;
    int               rx_cnt = 0;
    int               rx_words = 0;
    int               n_acc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called on the falling edge: compare outputs with the head of the expected stream.
    task automatic observe();
        logic ev, eb, ef;
        logic [WIDTH-1:0] w;
        ev = 1'b0; eb = 1'b0; ef = 1'b0;
        if (exp_q.size() > 0) begin
            ev = 1'b1;
            eb = exp_q[0].b;
            ef = exp_q[0].first;
        end
        chk("load_ready", 32'(load_ready), 32'(exp_q.size() <= 1));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("busy", 32'(busy), 32'(ev));
        chk("data_out", 32'(data_out), 32'(eb));
        chk("frame_start", 32'(frame_start), 32'(ef));
        if (out_valid === 1'b1) begin
            rx_word = {rx_word[WIDTH-2:0], data_out};
            rx_cnt++;
            if (rx_cnt == WIDTH) begin
                rx_cnt = 0;
                rx_words++;
                chk("rx_has_sent_word", 32'(sent_q.size() > 0), 32'd1);
                if (sent_q.size() > 0) begin
                    w = sent_q.pop_front();
                    chk("rx_word", 32'(rx_word), 32'(w));
                end
            end
        end
    endtask

    // Entered and left at one time unit after a rising edge.
    task automatic step(input logic lv, input logic [WIDTH-1:0] d);
        logic rdy;
        load_valid = lv;
        data_in    = d;
        @(negedge clk);
        observe();
        @(posedge clk);
        rdy = (exp_q.size() <= 1);
        if (exp_q.size() > 0) exp_q.delete(0);
        if (lv && rdy) begin
            for (int i = 0; i < WIDTH; i++) begin
                exp_q.push_back('{b: d[WIDTH-1-i], first: (i == 0)});
            end
            sent_q.push_back(d);
            n_acc++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_b      = 1'b0;
        load_valid = 1'b1;
        data_in    = WIDTH'($urandom);
        #1;
        exp_q.delete();
        sent_q.delete();
        rx_cnt = 0;
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
            chk("rst_hold_load_ready", 32'(load_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        rst_b      = 1'b1;
        load_valid = 1'b0;
    endtask

    initial begin
        int base_words;
        int cycles;

        @(posedge clk);
        #1;
        do_reset();

        // Single word, accepted on the first edge after reset release.
        step(1'b1, 8'hA5);
        repeat (10) step(1'b0, WIDTH'($urandom));

        // Back-to-back: junk data while busy, 3C presented at the last-bit slot.
        step(1'b1, 8'hA5);
        repeat (7) step(1'b1, WIDTH'($urandom));
        step(1'b1, 8'h3C);
        repeat (10) step(1'b0, WIDTH'($urandom));

        // Mid-word load attempts are ignored.
        step(1'b1, 8'hFF);
        repeat (7) step(1'($urandom), WIDTH'($urandom));
        step(1'b0, WIDTH'($urandom));
        repeat (3) step(1'b0, WIDTH'($urandom));

        // Reset after the third bit, then a clean word.
        step(1'b1, 8'hC3);
        repeat (3) step(1'b0, WIDTH'($urandom));
        do_reset();
        step(1'b1, 8'h81);
        repeat (10) step(1'b0, WIDTH'($urandom));

        // Random loopback of 100 words with random load gaps.
        base_words = rx_words;
        n_acc      = 0;
        cycles     = 0;
        while (n_acc < 100 && cycles < 5000) begin
            step(($urandom % 3) != 0, WIDTH'($urandom));
            cycles++;
        end
        chk("loop_accepts", 32'(n_acc), 32'd100);
        repeat (WIDTH + 2) step(1'b0, WIDTH'($urandom));
        chk("loop_rx_words", 32'(rx_words - base_words), 32'd100);
        chk("loop_sent_drained", 32'(sent_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
